// File: rtl/serial_word_comparator.sv
// serial_word_comparator: framed serial magnitude comparator.
// Two WORD_LEN-bit operands arrive DIGIT_W bits per accepted cycle, MSB- or
// LSB-first, and a one-cycle done pulse presents registered gt/lt/eq flags.
// Optional build macro SERIAL_CMP_SIGNED_EN selects two's-complement compare
// (the sign bit of the most significant digit is inverted before comparing).
module serial_word_comparator #(
    parameter int WORD_LEN = 8,
    parameter int DIGIT_W  = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               valid_in,
    input  logic               msb_first,
    input  logic [DIGIT_W-1:0] x_digit,
    input  logic [DIGIT_W-1:0] y_digit,
    output logic               busy,
    output logic               done,
    output logic               o_gt,
    output logic               o_lt,
    output logic               o_eq
);

    localparam int NDIG = WORD_LEN / DIGIT_W;
    localparam int CW   = $clog2(NDIG + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NDIG - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;
    typedef enum logic [1:0] {DEC_EQ, DEC_GT, DEC_LT} dec_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    dec_t            dec_q, dec_d;
    logic            msb_q, msb_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            gt_q, gt_d;
    logic            lt_q, lt_d;
    logic            eq_q, eq_d;

    logic               accept_start;
    logic               accept_run;
    logic               cur_msb;
    logic [CW-1:0]      cur_idx;
    logic               is_last;
    logic [DIGIT_W-1:0] xd;
    logic [DIGIT_W-1:0] yd;
    dec_t               cmp;
    dec_t               dec_base;
    dec_t               dec_new;

    // Digit datapath: which digit this is, its compare, and the updated decision.
    always_comb begin
        accept_start = start & valid_in;
        accept_run   = valid_in & ~start & (state_q == S_RUN);
        // A start always carries digit 0 and resamples the bit order.
        cur_msb  = accept_start ? msb_first : msb_q;
        cur_idx  = accept_start ? '0 : cnt_q;
        is_last  = (cur_idx == LAST_IDX);
        xd       = x_digit;
        yd       = y_digit;
`ifdef SERIAL_CMP_SIGNED_EN
        // Flipping the sign bit of the top digit maps two's complement onto
        // unsigned order, so the rest of the compare stays unsigned.
        if (cur_msb ? (cur_idx == '0) : is_last) begin
            xd[DIGIT_W-1] = ~x_digit[DIGIT_W-1];
            yd[DIGIT_W-1] = ~y_digit[DIGIT_W-1];
        end
`endif
        if (xd > yd) begin
            cmp = DEC_GT;
        end else if (xd < yd) begin
            cmp = DEC_LT;
        end else begin
            cmp = DEC_EQ;
        end
        dec_base = accept_start ? DEC_EQ : dec_q;
        if (cur_msb) begin
            // First difference from the top decides; later digits cannot change it.
            dec_new = (dec_base == DEC_EQ) ? cmp : dec_base;
        end else begin
            // Later digits are more significant, so any difference overrides.
            dec_new = (cmp != DEC_EQ) ? cmp : dec_base;
        end
    end

    // Next-state logic: word framing, digit counting and result loading.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        msb_d   = msb_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        if (accept_start || accept_run) begin
            dec_d = dec_new;
            cnt_d = cur_idx + 1'b1;
            if (accept_start) begin
                msb_d = msb_first;
                gt_d  = 1'b0;
                lt_d  = 1'b0;
                eq_d  = 1'b0;
            end
            if (is_last) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                dec_d   = DEC_EQ;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                gt_d    = (dec_new == DEC_GT);
                lt_d    = (dec_new == DEC_LT);
                eq_d    = (dec_new == DEC_EQ);
            end else begin
                state_d = S_RUN;
                busy_d  = 1'b1;
            end
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dec_q   <= DEC_EQ;
            msb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            msb_q   <= msb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign o_gt = gt_q;
    assign o_lt = lt_q;
    assign o_eq = eq_q;

endmodule

// File: tb/tb_serial_word_comparator.sv
// Directed bench for serial_word_comparator: three instances cover
// 8-bit/1-bit digits, 8-bit/4-bit digits and a single-digit 4-bit word.
module tb_serial_word_comparator;

    localparam logic [2:0] R_NONE = 3'b000;
    localparam logic [2:0] R_GT   = 3'b100;
    localparam logic [2:0] R_LT   = 3'b010;
    localparam logic [2:0] R_EQ   = 3'b001;

`ifdef SERIAL_CMP_SIGNED_EN
    localparam logic [2:0] E_80_01   = R_LT;
    localparam logic [2:0] E_01_80   = R_GT;
    localparam logic [2:0] E_91_19   = R_LT;
`else
    localparam logic [2:0] E_80_01   = R_GT;
    localparam logic [2:0] E_01_80   = R_LT;
    localparam logic [2:0] E_91_19   = R_GT;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // 8-bit word, 1-bit digits
    logic       s1, v1, m1;
    logic [0:0] x1, y1;
    logic       b1, d1, gt1, lt1, eq1;
    // 8-bit word, 4-bit digits
    logic       s4, v4, m4;
    logic [3:0] x4, y4;
    logic       b4, d4, gt4, lt4, eq4;
    // 4-bit word, 4-bit digit
    logic       s44, v44, m44;
    logic [3:0] x44, y44;
    logic       b44, d44, gt44, lt44, eq44;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    serial_word_comparator #(.WORD_LEN(8), .DIGIT_W(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(s1), .valid_in(v1), .msb_first(m1),
        .x_digit(x1), .y_digit(y1), .busy(b1), .done(d1),
        .o_gt(gt1), .o_lt(lt1), .o_eq(eq1));

    serial_word_comparator #(.WORD_LEN(8), .DIGIT_W(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .start(s4), .valid_in(v4), .msb_first(m4),
        .x_digit(x4), .y_digit(y4), .busy(b4), .done(d4),
        .o_gt(gt4), .o_lt(lt4), .o_eq(eq4));

    serial_word_comparator #(.WORD_LEN(4), .DIGIT_W(4)) u_dut44 (
        .clk(clk), .reset_n(reset_n), .start(s44), .valid_in(v44), .msb_first(m44),
        .x_digit(x44), .y_digit(y44), .busy(b44), .done(d44),
        .o_gt(gt44), .o_lt(lt44), .o_eq(eq44));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive nd digits of a word into the 1-bit instance, starting with a start.
    // prev_mode: 0 = no check on first cycle, 1 = previous word completes now,
    // 2 = previous word still busy (restart case).
    task automatic send1(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input logic msb, input int nd, input int prev_mode,
                         input logic [2:0] prev_exp);
        $display("word %s: x=%h y=%h msb_first=%0d digits=%0d", tag, x, y, msb, nd);
        for (int i = 0; i < nd; i++) begin
            @(negedge clk);
            if (i == 0) begin
                if (prev_mode == 1) begin
                    check({tag, " prev done"}, 32'(d1), 32'd1);
                    check({tag, " prev result"}, 32'({gt1, lt1, eq1}), 32'(prev_exp));
                end else if (prev_mode == 2) begin
                    check({tag, " prev busy"}, 32'(b1), 32'd1);
                    check({tag, " prev no done"}, 32'(d1), 32'd0);
                end
            end else begin
                check({tag, " busy"}, 32'(b1), 32'd1);
                check({tag, " done early"}, 32'(d1), 32'd0);
                check({tag, " result cleared"}, 32'({gt1, lt1, eq1}), 32'(R_NONE));
            end
            s1 = (i == 0);
            v1 = 1'b1;
            m1 = msb;
            x1 = msb ? x[7-i] : x[i];
            y1 = msb ? y[7-i] : y[i];
        end
    endtask

    // Final digit has been driven: check the done cycle and the cycle after.
    task automatic end1(input string tag, input logic [2:0] exp);
        @(negedge clk);
        check({tag, " done"}, 32'(d1), 32'd1);
        check({tag, " busy low"}, 32'(b1), 32'd0);
        check({tag, " result"}, 32'({gt1, lt1, eq1}), 32'(exp));
        s1 = 1'b0;
        v1 = 1'b0;
        @(negedge clk);
        check({tag, " done pulse"}, 32'(d1), 32'd0);
        check({tag, " result held"}, 32'({gt1, lt1, eq1}), 32'(exp));
    endtask

    initial begin
        reset_n = 1'b0;
        s1 = 0; v1 = 0; m1 = 0; x1 = 0; y1 = 0;
        s4 = 0; v4 = 0; m4 = 0; x4 = 0; y4 = 0;
        s44 = 0; v44 = 0; m44 = 0; x44 = 0; y44 = 0;
        repeat (2) @(negedge clk);
        check("reset dut1", 32'({b1, d1, gt1, lt1, eq1}), 32'd0);
        check("reset dut4", 32'({b4, d4, gt4, lt4, eq4}), 32'd0);
        check("reset dut44", 32'({b44, d44, gt44, lt44, eq44}), 32'd0);
        reset_n = 1'b1;

        // Basic MSB-first and LSB-first words
        send1("a5a3_msb", 8'hA5, 8'hA3, 1'b1, 8, 0, R_NONE);
        end1("a5a3_msb", R_GT);
        send1("a5a3_lsb", 8'hA5, 8'hA3, 1'b0, 8, 0, R_NONE);
        end1("a5a3_lsb", R_GT);
        send1("0180_lsb", 8'h01, 8'h80, 1'b0, 8, 0, R_NONE);
        end1("0180_lsb", E_01_80);
        send1("8001_msb", 8'h80, 8'h01, 1'b1, 8, 0, R_NONE);
        end1("8001_msb", E_80_01);
        send1("8001_lsb", 8'h80, 8'h01, 1'b0, 8, 0, R_NONE);
        end1("8001_lsb", E_80_01);

        // Valid without start and start without valid are both ignored
        $display("word idle_ignore: stray valid and stray start");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("ignore busy", 32'(b1), 32'd0);
            check("ignore done", 32'(d1), 32'd0);
            check("ignore result", 32'({gt1, lt1, eq1}), 32'(E_80_01));
            s1 = (k == 2);
            v1 = (k != 2);
            x1 = 1'b1;
            y1 = 1'b0;
        end
        @(negedge clk);
        check("ignore busy end", 32'(b1), 32'd0);
        check("ignore result end", 32'({gt1, lt1, eq1}), 32'(E_80_01));
        s1 = 1'b0;
        v1 = 1'b0;

        // Restart after 3 digits: first word gives no done
        send1("rs_first", 8'hFF, 8'h00, 1'b1, 3, 0, R_NONE);
        send1("rs_second", 8'h12, 8'h34, 1'b1, 8, 2, R_NONE);
        end1("rs_second", R_LT);

        // Back-to-back: second start in the done cycle
        send1("b2b_1", 8'h10, 8'h20, 1'b1, 8, 0, R_NONE);
        send1("b2b_2", 8'h20, 8'h10, 1'b1, 8, 1, R_LT);
        end1("b2b_2", R_GT);

        // Reset in IDLE clears held results
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("idle reset result", 32'({gt1, lt1, eq1}), 32'(R_NONE));
        @(negedge clk);
        reset_n = 1'b1;

        // Reset mid-word: outputs drop at once, no done follows
        send1("rst_mid", 8'hFF, 8'h00, 1'b1, 4, 0, R_NONE);
        @(negedge clk);
        s1 = 1'b0;
        v1 = 1'b0;
        check("mid busy before reset", 32'(b1), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid reset outputs", 32'({b1, d1, gt1, lt1, eq1}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post reset no done", 32'({b1, d1}), 32'd0);
        end

        // 4-bit digits, 3 stall cycles between the two digits
        $display("word d4_stall: x=3c y=3c msb_first=1");
        @(negedge clk);
        s4 = 1'b1; v4 = 1'b1; m4 = 1'b1; x4 = 4'h3; y4 = 4'h3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("d4 stall busy", 32'(b4), 32'd1);
            check("d4 stall done", 32'(d4), 32'd0);
            s4 = 1'b0;
            v4 = 1'b0;
        end
        @(negedge clk);
        check("d4 stall busy last", 32'(b4), 32'd1);
        v4 = 1'b1; x4 = 4'hC; y4 = 4'hC;
        @(negedge clk);
        check("d4 stall done", 32'(d4), 32'd1);
        check("d4 stall busy low", 32'(b4), 32'd0);
        check("d4 stall result", 32'({gt4, lt4, eq4}), 32'(R_EQ));
        v4 = 1'b0;

        // 4-bit digits LSB-first: the upper digit overrides the lower one
        $display("word d4_lsb: x=91 y=19 msb_first=0");
        @(negedge clk);
        s4 = 1'b1; v4 = 1'b1; m4 = 1'b0; x4 = 4'h1; y4 = 4'h9;
        @(negedge clk);
        check("d4 lsb busy", 32'(b4), 32'd1);
        s4 = 1'b0; x4 = 4'h9; y4 = 4'h1;
        @(negedge clk);
        check("d4 lsb done", 32'(d4), 32'd1);
        check("d4 lsb result", 32'({gt4, lt4, eq4}), 32'(E_91_19));
        v4 = 1'b0;

        // Single-digit word: done the cycle after start, back-to-back
        $display("word d44: x=3 y=2 then x=7 y=7");
        @(negedge clk);
        s44 = 1'b1; v44 = 1'b1; m44 = 1'b1; x44 = 4'h3; y44 = 4'h2;
        @(negedge clk);
        check("d44 done1", 32'(d44), 32'd1);
        check("d44 busy1", 32'(b44), 32'd0);
        check("d44 result1", 32'({gt44, lt44, eq44}), 32'(R_GT));
        x44 = 4'h7; y44 = 4'h7;
        @(negedge clk);
        check("d44 done2", 32'(d44), 32'd1);
        check("d44 result2", 32'({gt44, lt44, eq44}), 32'(R_EQ));
        s44 = 1'b0; v44 = 1'b0;
        @(negedge clk);
        check("d44 done pulse", 32'(d44), 32'd0);
        check("d44 result held", 32'({gt44, lt44, eq44}), 32'(R_EQ));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
